// File: rtl/pwm_pkg.sv
// Types shared by the PWM generator and its duty slew-rate limiter.
package pwm_pkg;

   typedef logic [7:0] duty_t;

   localparam duty_t DUTY_MIN = 8'd0;
   localparam duty_t DUTY_MAX = 8'd255;

   typedef enum logic [1:0] {IDLE, UP, DOWN} ramp_state_t;

endpackage

// File: rtl/step_prescaler.sv
// Free-running prescaler: tick is high in the last cycle of every STEP_DIV-cycle window.
module step_prescaler #(
   parameter int unsigned STEP_DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slews the PWM duty toward target by STEP per tick, updating only at period starts.
// Define DUTY_RAMP_SYNC_EN to pass target through a 2-flop synchronizer first.
module pwm_duty_ramp
   import pwm_pkg::*;
#(
   parameter int unsigned STEP_DIV = 100000,
   parameter int unsigned STEP     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] target,
   input  logic       period_start,
   output logic [7:0] duty,
   output logic       busy,
   output logic       done
);

   localparam logic [8:0] STEP9 = 9'(STEP);

   duty_t       tgt;
   duty_t       duty_q;
   duty_t       duty_d;
   logic        pending_q;
   logic        pending_d;
   logic        done_q;
   logic        done_d;
   logic        tick;
   logic        upd;
   logic [8:0]  sum9;
   logic [8:0]  dif9;
   ramp_state_t state_c;

   step_prescaler #(
      .STEP_DIV (STEP_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

`ifdef DUTY_RAMP_SYNC_EN
   duty_t sync1_q;
   duty_t sync2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= target;
         sync2_q <= sync1_q;
      end
   end

   assign tgt = sync2_q;
`else
   assign tgt = target;
`endif

   // Direction is re-derived every cycle so a target change retargets immediately.
   always_comb begin
      state_c = IDLE;
      if (duty_q < tgt) begin
         state_c = UP;
      end else if (duty_q > tgt) begin
         state_c = DOWN;
      end
   end

   // 9-bit step math; an overshoot or borrow clamps to target.
   always_comb begin
      sum9      = {1'b0, duty_q} + STEP9;
      dif9      = {1'b0, duty_q} - STEP9;
      upd       = period_start & (pending_q | tick);
      duty_d    = duty_q;
      pending_d = pending_q | tick;
      done_d    = 1'b0;
      if (upd) begin
         pending_d = 1'b0;
         case (state_c)
            UP:      duty_d = (sum9 > {1'b0, tgt}) ? tgt : sum9[7:0];
            DOWN:    duty_d = (dif9[8] || (dif9[7:0] < tgt)) ? tgt : dif9[7:0];
            default: duty_d = duty_q;
         endcase
         done_d = (state_c != IDLE) && (duty_d == tgt);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         duty_q    <= DUTY_MIN;
         pending_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         duty_q    <= duty_d;
         pending_q <= pending_d;
         done_q    <= done_d;
      end
   end

   assign duty = duty_q;
   assign busy = (state_c != IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: one STEP=1 and one STEP=16 instance, expected duty/done queued per update.
module tb_pwm_duty_ramp;

   typedef struct {
      int   d1;
      logic dn1;
      int   d16;
      logic dn16;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       period_start;
   logic [7:0] target1;
   logic [7:0] target16;
   logic [7:0] duty1;
   logic [7:0] duty16;
   logic       busy1;
   logic       busy16;
   logic       done1;
   logic       done16;

   int   checks = 0;
   int   errors = 0;
   int   exp1   = 0;
   int   exp16  = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   pwm_duty_ramp #(.STEP_DIV(4), .STEP(1)) u_dut1 (
      .clk          (clk),
      .rst          (rst),
      .target       (target1),
      .period_start (period_start),
      .duty         (duty1),
      .busy         (busy1),
      .done         (done1)
   );

   pwm_duty_ramp #(.STEP_DIV(4), .STEP(16)) u_dut16 (
      .clk          (clk),
      .rst          (rst),
      .target       (target16),
      .period_start (period_start),
      .duty         (duty16),
      .busy         (busy16),
      .done         (done16)
   );

   function automatic int nxt(input int d, input int t, input int s);
      if (d < t) return (d + s > t) ? t : d + s;
      if (d > t) return (d - s < t) ? t : d - s;
      return d;
   endfunction

   // Idle for 'idle' cycles (a tick always lands in that window), then one period_start.
   task automatic do_update(input int idle);
      exp_t e;
      exp_t g;
      period_start = 1'b0;
      for (int i = 0; i < idle; i++) @(negedge clk);
      checks += 2;
      if (busy1 !== (exp1 != int'(target1))) begin
         errors++;
         $display("FAIL busy1 got %0b want %0b", busy1, exp1 != int'(target1));
      end
      if (busy16 !== (exp16 != int'(target16))) begin
         errors++;
         $display("FAIL busy16 got %0b want %0b", busy16, exp16 != int'(target16));
      end
      period_start = 1'b1;
      e.d1  = nxt(exp1, int'(target1), 1);
      e.dn1 = (exp1 != int'(target1)) && (e.d1 == int'(target1));
      e.d16  = nxt(exp16, int'(target16), 16);
      e.dn16 = (exp16 != int'(target16)) && (e.d16 == int'(target16));
      sb.push_back(e);
      exp1  = e.d1;
      exp16 = e.d16;
      @(negedge clk);
      period_start = 1'b0;
      g = sb.pop_front();
      checks += 4;
      if (int'(duty1) !== g.d1) begin
         errors++;
         $display("FAIL duty1 got %0d want %0d", duty1, g.d1);
      end
      if (done1 !== g.dn1) begin
         errors++;
         $display("FAIL done1 got %0b want %0b (duty %0d)", done1, g.dn1, duty1);
      end
      if (int'(duty16) !== g.d16) begin
         errors++;
         $display("FAIL duty16 got %0d want %0d", duty16, g.d16);
      end
      if (done16 !== g.dn16) begin
         errors++;
         $display("FAIL done16 got %0b want %0b (duty %0d)", done16, g.dn16, duty16);
      end
      @(negedge clk);
      checks += 1;
      if ((done1 | done16) !== 1'b0) begin
         errors++;
         $display("FAIL done_width got %0b/%0b want 0/0", done1, done16);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      period_start = 1'b0;
      target1 = 8'd0;
      target16 = 8'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks += 1;
      if ({duty1, busy1, done1, duty16, busy16, done16} !== 20'd0) begin
         errors++;
         $display("FAIL reset_state got %0d/%0b/%0b %0d/%0b/%0b want zeros",
                  duty1, busy1, done1, duty16, busy16, done16);
      end
      for (int i = 0; i < 12; i++) begin
         period_start = (i % 3 == 2);
         @(negedge clk);
         checks += 1;
         if ({duty1, done1, duty16, done16} !== 18'd0) begin
            errors++;
            $display("FAIL idle_zero got %0d/%0b %0d/%0b want 0/0", duty1, done1, duty16, done16);
         end
      end
      period_start = 1'b0;
   endtask

   task automatic test_ramp_up();
      target1 = 8'd3;
      for (int i = 0; i < 3; i++) do_update(7);
      checks += 2;
      if (duty1 !== 8'd3) begin
         errors++;
         $display("FAIL ramp_up_final got %0d want 3", duty1);
      end
      if (busy1 !== 1'b0) begin
         errors++;
         $display("FAIL ramp_up_busy got %0b want 0", busy1);
      end
   endtask

   task automatic test_clamp();
      target16 = 8'd250;
      while (exp16 != 250) do_update(6);
      target16 = 8'd255;
      do_update(6);
      checks += 1;
      if (duty16 !== 8'd255) begin
         errors++;
         $display("FAIL clamp_top got %0d want 255", duty16);
      end
      target16 = 8'd5;
      while (exp16 != 5) do_update(6);
      target16 = 8'd0;
      do_update(6);
      checks += 1;
      if (duty16 !== 8'd0) begin
         errors++;
         $display("FAIL clamp_bottom got %0d want 0", duty16);
      end
   endtask

   task automatic test_rst_mid();
      target1 = 8'd100;
      while (exp1 < 40) do_update(6);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp1 = 0;
      exp16 = 0;
      checks += 1;
      if ({duty1, done1, duty16, done16} !== 18'd0) begin
         errors++;
         $display("FAIL rst_mid got %0d/%0b %0d/%0b want 0/0", duty1, done1, duty16, done16);
      end
      @(negedge clk);
      period_start = 1'b1;
      @(negedge clk);
      period_start = 1'b0;
      checks += 1;
      if (duty1 !== 8'd0) begin
         errors++;
         $display("FAIL rst_pending got %0d want 0", duty1);
      end
      repeat (2) @(negedge clk);
      checks += 1;
      if (busy1 !== 1'b1) begin
         errors++;
         $display("FAIL rst_busy got %0b want 1", busy1);
      end
   endtask

   task automatic test_reverse();
      target1 = 8'd120;
      while (exp1 < 100) do_update(6);
      target1 = 8'd90;
      while (exp1 != 90) begin
         do_update(6);
         checks += 1;
         if (duty1 > 8'd100) begin
            errors++;
            $display("FAIL reverse_overshoot got %0d want <=100", duty1);
         end
      end
   endtask

   task automatic test_many_ticks();
      target1 = 8'd95;
      target16 = 8'd200;
      do_update(40);
      checks += 2;
      if (duty1 !== 8'd91) begin
         errors++;
         $display("FAIL many_ticks1 got %0d want 91", duty1);
      end
      if (duty16 !== 8'd16) begin
         errors++;
         $display("FAIL many_ticks16 got %0d want 16", duty16);
      end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_clamp();
      test_rst_mid();
      test_reverse();
      test_many_ticks();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
